word_bank_arbiter: RTL and testbench
====================================

Name: word_bank_arbiter

Overview:
- Round-robin arbiter and sequencer that shares a small bank of Word registers between Req requesters.
- Each granted requester performs one single-word read or write per grant.
- A bulk-clear sequencer walks every address and writes the RST value, blocking requesters while it runs.
- Sits between the genetic datapath engines and the memory bank, in the memory subsystem.

Parameters:
- Width, 8: bits per word.
- Depth, 4: number of words in the bank.
- AddrW, 2: address width; Depth <= 2**AddrW.
- Req, 2: number of requesters.
- RST, {Width{1'b0}}: value loaded into words on reset and during bulk clear.
- PST, {Width{1'b1}}: value loaded during bulk preset; used only with PRESET_EN.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- req  in  Req  per-requester access request, level.
- we  in  Req  per-requester write enable; 1 = write, 0 = read.
- addr  in  Req*AddrW  flattened addresses; requester i owns bits [i*AddrW +: AddrW].
- din  in  Req*Width  flattened write data; requester i owns bits [i*Width +: Width].
- clr  in  1  bulk-clear command, sampled in IDLE only.
- gnt  out  Req  registered one-hot grant; high for the cycle after the access is performed.
- dout  out  Width  registered read data; valid while gnt is high for a read.
- busy  out  1  high while a bulk sequence is running.

Behaviour:
- Reset (rst=1 at an edge):
  - all Depth words = RST.
  - gnt = 0, dout = 0, busy = 0.
  - round-robin pointer = 0, so requester 0 has highest priority.
  - FSM = IDLE.
  - rst overrides everything, including a sequence in progress; the sequence is aborted.
- FSM states: IDLE and CLEAR (plus PRESET with PRESET_EN).
- IDLE arbitration, evaluated every edge:
  - Scan req starting from the pointer, wrapping modulo Req; the first asserted requester k wins.
  - At that edge, if we[k]=1, word[addr_k] <= din_k and dout is unchanged. If we[k]=0, dout <= word[addr_k], giving one-cycle read latency.
  - Also at that edge: gnt <= one-hot(k) and pointer <= (k+1) mod Req.
  - If no req is asserted: gnt <= 0 and the pointer holds.
- Handshake:
  - A requester holds req, we, addr and din stable until it sees its gnt bit.
  - req still high while gnt is high means a new transaction; the requester updates addr/din/we in that same cycle.
  - At most one access per cycle; every requester with req held is granted within Req cycles.
- Out-of-range address (addr >= Depth):
  - A write is dropped.
  - A read returns RST.
  - gnt is still issued.
- IDLE with clr=1 at an edge:
  - Go to CLEAR, set busy <= 1 and counter <= 0.
  - No grant that edge; clr has priority over req.
- CLEAR:
  - Each edge: word[counter] <= RST, counter increments, gnt <= 0.
  - req is ignored and stays pending; the pointer holds.
  - The edge that writes word[Depth-1] returns the FSM to IDLE with busy <= 0.
  - Total duration is exactly Depth cycles with busy high.
  - Arbitration resumes on the first edge after busy falls.
- clr asserted during CLEAR is ignored; it does not restart or extend the sequence.
- dout retains its last value through a sequence.

Optional Feature:
- Macro: PRESET_EN.
- Defined:
  - Adds input port pst (1 bit) after clr.
  - IDLE with pst=1 enters PRESET, which is identical to CLEAR but writes PST.
  - clr and pst together: clr wins.
  - pst during either sequence is ignored.
- Undefined:
  - No pst port and no PRESET state.
  - The PST parameter is accepted but unused.

Test Plan:
- Reset then read: rst high 1 cycle, then requester 0 reads addr 2 -> gnt=01 the next cycle, dout=8'h00.
- Write/readback: requester 1 writes 8'hA5 to addr 3, then reads addr 3 -> gnt=10 on both transactions, dout=8'hA5 on the read.
- Fairness: req=11 held 6 cycles, both reading -> gnt sequence 01,10,01,10,01,10.
- Clear vs request: addr 0..3 written 8'h11..8'h44, then clr=1 with req=01 in the same cycle -> busy high exactly 4 cycles, gnt=0 during, then gnt=01; subsequent reads of every address return 8'h00.
- Reset mid-clear: rst asserted on the 2nd CLEAR cycle -> the next cycle has busy=0, gnt=0 and all words 8'h00.
- PRESET_EN: pst=1 in IDLE -> busy high 4 cycles; all reads return 8'hFF. pst=1 and clr=1 together -> all reads return 8'h00.

Source files
------------

// File: rtl/word_bank_arbiter.sv
// Round-robin arbiter sharing a small word bank between requesters, with a bulk-clear sequencer.
// Optional macro PRESET_EN adds an i_pst input and a PRESET sequence that fills the bank with PST.
//
// state     | meaning
// ST_IDLE   | arbitrating requesters, one access per edge
// ST_CLEAR  | walking every address, writing RST
// ST_PRESET | walking every address, writing PST (PRESET_EN only)
module word_bank_arbiter #(
  parameter int Width = 8,
  parameter int Depth = 4,
  parameter int AddrW = 2,
  parameter int Req   = 2,
  parameter logic [Width-1:0] RST = {Width{1'b0}},
  parameter logic [Width-1:0] PST = {Width{1'b1}}
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [Req-1:0]         i_req,
  input  logic [Req-1:0]         i_we,
  input  logic [Req*AddrW-1:0]   i_addr,
  input  logic [Req*Width-1:0]   i_din,
  input  logic                   i_clr,
`ifdef PRESET_EN
  input  logic                   i_pst,
`endif
  output logic [Req-1:0]         o_gnt,
  output logic [Width-1:0]       o_dout,
  output logic                   o_busy
);

  localparam int PtrW = (Req > 1) ? $clog2(Req) : 1;

`ifdef PRESET_EN
  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_PRESET} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR} state_t;
`endif

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PtrW-1:0]      r_ptr;
  logic [AddrW-1:0]     r_cnt;
  logic [Width-1:0]     r_mem [Depth];
  logic [Req-1:0]       r_gnt;
  logic [Width-1:0]     r_dout;
  logic                 r_busy;

  logic                 w_found;
  logic [PtrW-1:0]      w_win;
  logic [PtrW-1:0]      w_ptr_nxt;
  logic [Req-1:0]       w_gnt_nxt;
  logic [AddrW-1:0]     w_addr;
  logic                 w_we;
  logic [Width-1:0]     w_din;
  logic                 w_in_range;
  logic [Width-1:0]     w_rdata;
  logic                 w_cnt_last;
  logic                 w_preset;
  logic [Width-1:0]     w_fill;

  function automatic logic [PtrW-1:0] wrap_idx(input logic [PtrW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= Req) s = s - Req;
    return PtrW'(s);
  endfunction

  // First asserted request at or after the pointer, wrapping around
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < Req; i++) begin
      if (!w_found && i_req[wrap_idx(r_ptr, i)]) begin
        w_found = 1'b1;
        w_win   = wrap_idx(r_ptr, i);
      end
    end
  end

  always_comb begin
    w_addr    = '0;
    w_we      = 1'b0;
    w_din     = '0;
    w_gnt_nxt = '0;
    for (int i = 0; i < Req; i++) begin
      if (w_win == PtrW'(i)) begin
        w_addr       = i_addr[i*AddrW +: AddrW];
        w_we         = i_we[i];
        w_din        = i_din[i*Width +: Width];
        w_gnt_nxt[i] = w_found;
      end
    end
  end

  assign w_ptr_nxt  = (w_win == PtrW'(Req-1)) ? '0 : w_win + PtrW'(1);
  assign w_in_range = ({1'b0, w_addr} < (AddrW+1)'(Depth));
  assign w_rdata    = w_in_range ? r_mem[w_addr] : RST;
  assign w_cnt_last = (r_cnt == AddrW'(Depth-1));

`ifdef PRESET_EN
  assign w_preset = (r_state == ST_PRESET);
`else
  assign w_preset = 1'b0;
`endif
  assign w_fill = w_preset ? PST : RST;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_clr) w_state_nxt = ST_CLEAR;
`ifdef PRESET_EN
        else if (i_pst) w_state_nxt = ST_PRESET;
`endif
      end
      default: begin
        if (w_cnt_last) w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < Depth; i++) r_mem[i] <= RST;
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_dout  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_gnt   <= '0;
      if (r_state == ST_IDLE) begin
        r_cnt <= '0;
        // A sequence start takes priority over any pending request
        if (w_state_nxt == ST_IDLE && w_found) begin
          r_gnt <= w_gnt_nxt;
          r_ptr <= w_ptr_nxt;
          if (w_we) begin
            if (w_in_range) r_mem[w_addr] <= w_din;
          end else begin
            r_dout <= w_rdata;
          end
        end
      end else begin
        r_mem[r_cnt] <= w_fill;
        r_cnt        <= r_cnt + AddrW'(1);
      end
    end
  end

  assign o_gnt  = r_gnt;
  assign o_dout = r_dout;
  assign o_busy = r_busy;

endmodule

// File: tb/tb_word_bank_arbiter.sv
// Scoreboard bench for word_bank_arbiter: a behavioural model predicts gnt/dout/busy per edge,
// a monitor compares DUT outputs against the queued predictions.
module tb_word_bank_arbiter;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AW = 2;
  localparam int R  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [R-1:0]    req, we;
  logic [R*AW-1:0] addr;
  logic [R*W-1:0]  din;
  logic            clr;
`ifdef PRESET_EN
  logic            pst;
`endif
  logic [R-1:0]    gnt;
  logic [W-1:0]    dout;
  logic            busy;

  word_bank_arbiter #(.Width(W), .Depth(D), .AddrW(AW), .Req(R)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr), .i_din(din),
    .i_clr(clr),
`ifdef PRESET_EN
    .i_pst(pst),
`endif
    .o_gnt(gnt), .o_dout(dout), .o_busy(busy));

  typedef struct {
    logic [R-1:0] gnt;
    logic [W-1:0] dout;
    logic         busy;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   edge_no = 0;

  // reference model state
  logic [W-1:0] m_mem [D];
  int           m_ptr;
  int           m_left;
  logic [W-1:0] m_fill;
  logic [W-1:0] m_dout;
  logic [R-1:0] m_gnt;

  // requester-side pending transactions for random traffic
  bit           p_act  [R];
  bit           p_we   [R];
  int           p_addr [R];
  logic [W-1:0] p_din  [R];

  task automatic model_step(output exp_t e);
    int  k;
    int  a;
    bit  pst_v;
    pst_v = 1'b0;
`ifdef PRESET_EN
    pst_v = pst;
`endif
    m_gnt = '0;
    if (rst) begin
      for (int i = 0; i < D; i++) m_mem[i] = 8'h00;
      m_ptr  = 0;
      m_left = 0;
      m_dout = 8'h00;
    end else if (m_left > 0) begin
      m_mem[D - m_left] = m_fill;
      m_left = m_left - 1;
    end else if (clr) begin
      m_left = D;
      m_fill = 8'h00;
    end else if (pst_v) begin
      m_left = D;
      m_fill = 8'hFF;
    end else begin
      k = -1;
      for (int i = 0; i < R; i++)
        if (k < 0 && req[(m_ptr + i) % R]) k = (m_ptr + i) % R;
      if (k >= 0) begin
        m_gnt[k] = 1'b1;
        m_ptr    = (k + 1) % R;
        a        = int'(addr[k*AW +: AW]);
        if (we[k]) begin
          if (a < D) m_mem[a] = din[k*W +: W];
        end else begin
          m_dout = (a < D) ? m_mem[a] : 8'h00;
        end
      end
    end
    e.gnt  = m_gnt;
    e.dout = m_dout;
    e.busy = (m_left > 0);
  endtask

  task automatic step();
    exp_t e;
    model_step(e);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic access(input int r, input bit w, input int a, input logic [W-1:0] d);
    req = '0;
    we  = '0;
    req[r] = 1'b1;
    we[r]  = w;
    addr[r*AW +: AW] = AW'(a);
    din[r*W +: W]    = d;
    step();
    req = '0;
  endtask

  task automatic fill_words();
    for (int a = 0; a < D; a++) access(0, 1'b1, a, W'((a + 1) * 8'h11));
  endtask

  task automatic read_all();
    for (int a = 0; a < D; a++) access(a % R, 1'b0, a, 8'h00);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      edge_no++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (gnt !== e.gnt || dout !== e.dout || busy !== e.busy) begin
          miscompares++;
          $display("FAIL outputs @edge %0d: got gnt=%b dout=%h busy=%b, expected gnt=%b dout=%h busy=%b",
                   edge_no, gnt, dout, busy, e.gnt, e.dout, e.busy);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; clr = 1'b0; req = '0; we = '0; addr = '0; din = '0;
`ifdef PRESET_EN
    pst = 1'b0;
`endif
    for (int i = 0; i < R; i++) begin
      p_act[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = 0; p_din[i] = '0;
    end

    // reset, then read from reset state
    step();
    rst = 1'b0;
    access(0, 1'b0, 2, 8'h00);

    // write / readback on requester 1
    access(1, 1'b1, 3, 8'hA5);
    access(1, 1'b0, 3, 8'h00);

    // fairness: both requesters hold read requests
    req = 2'b11; we = 2'b00;
    addr[0 +: AW] = 2'd3; addr[AW +: AW] = 2'd1;
    repeat (6) step();
    req = '0;

    // clear racing a request
    fill_words();
    req = 2'b01; we = 2'b00; addr[0 +: AW] = 2'd0; clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (D + 1) step();
    req = '0;
    read_all();

    // clr during CLEAR is ignored
    fill_words();
    clr = 1'b1;
    repeat (3) step();
    clr = 1'b0;
    repeat (D) step();
    read_all();

    // reset on the second CLEAR cycle
    fill_words();
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    read_all();

`ifdef PRESET_EN
    pst = 1'b1;
    step();
    pst = 1'b0;
    repeat (D) step();
    read_all();
    pst = 1'b1; clr = 1'b1;
    step();
    pst = 1'b0; clr = 1'b0;
    repeat (D) step();
    read_all();
`endif

    // random traffic with well-behaved requesters
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      clr = ($urandom_range(0, 29) == 0);
`ifdef PRESET_EN
      pst = ($urandom_range(0, 29) == 0);
`endif
      for (int i = 0; i < R; i++) begin
        if (!p_act[i] && $urandom_range(0, 2) != 0) begin
          p_act[i]  = 1'b1;
          p_we[i]   = $urandom_range(0, 1) == 1;
          p_addr[i] = $urandom_range(0, D - 1);
          p_din[i]  = W'($urandom);
        end
        req[i] = p_act[i];
        we[i]  = p_we[i];
        addr[i*AW +: AW] = AW'(p_addr[i]);
        din[i*W +: W]    = p_din[i];
      end
      step();
      for (int i = 0; i < R; i++) if (m_gnt[i]) p_act[i] = 1'b0;
    end

    rst = 1'b0; clr = 1'b0; req = '0;
`ifdef PRESET_EN
    pst = 1'b0;
`endif
    repeat (D + 1) step();
    read_all();
    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
